// File: rtl/fetch_sequencer.sv
// fetch_sequencer: program-counter sequencing controller (start, stall, redirect, halt)
// Ports:
//   i_clk, i_rst          clock; asynchronous active-high reset
//   i_start               leave IDLE and begin fetching
//   i_stall_req           hazard unit freeze request
//   i_branch_req          taken branch/jump from execute, with i_branch_target
//   i_halt_req            halt instruction seen in decode
//   o_pc_rst/ena/jmp      PC control, o_pc_jmp_in is the redirect address
//   o_flush_if/o_flush_id squash pulses, high only during a redirect
//   o_halted              high while halted
//   o_stall_count         saturating count of cycles spent stalled
module fetch_sequencer #(
    parameter int bus_counter = 5,
    parameter int cnt_width   = 8
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_start,
    input  logic                   i_stall_req,
    input  logic                   i_branch_req,
    input  logic [bus_counter-1:0] i_branch_target,
    input  logic                   i_halt_req,
    output logic                   o_pc_rst,
    output logic                   o_pc_ena,
    output logic                   o_pc_jmp,
    output logic [bus_counter-1:0] o_pc_jmp_in,
    output logic                   o_flush_if,
    output logic                   o_flush_id,
    output logic                   o_halted,
    output logic [cnt_width-1:0]   o_stall_count
);
    typedef enum logic [2:0] {IDLE, RUN, STALL, REDIRECT, HALT} state_t;
    state_t                 r_state;
    state_t                 w_next;
    logic                   r_pc_rst;
    logic                   r_pc_ena;
    logic                   r_pc_jmp;
    logic                   r_flush;
    logic                   r_halted;
    logic [bus_counter-1:0] r_pc_jmp_in;
    logic [cnt_width-1:0]   r_stall_count;
    // RUN and STALL share one priority: branch over halt over stall
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:     w_next = i_start ? RUN : IDLE;
            RUN,
            STALL:    w_next = i_branch_req ? REDIRECT : i_halt_req ? HALT : i_stall_req ? STALL : RUN;
            REDIRECT: w_next = RUN;
            HALT:     w_next = HALT;
            default:  w_next = IDLE;
        endcase
    end
    // Outputs are decoded from the next state so they are stable before the PC's negedge
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state       <= IDLE;
            r_pc_rst      <= 1'b1;
            r_pc_ena      <= 1'b0;
            r_pc_jmp      <= 1'b0;
            r_flush       <= 1'b0;
            r_halted      <= 1'b0;
            r_pc_jmp_in   <= '0;
            r_stall_count <= '0;
        end else begin
            r_state  <= w_next;
            r_pc_rst <= w_next == IDLE;
            r_pc_ena <= w_next == RUN || w_next == REDIRECT;
            r_pc_jmp <= w_next == REDIRECT;
            r_flush  <= w_next == REDIRECT;
            r_halted <= w_next == HALT;
            // REDIRECT lasts one cycle, so next==REDIRECT only on its entry edge
            if (w_next == REDIRECT)
                r_pc_jmp_in <= i_branch_target;
            if (w_next == STALL && r_stall_count != '1)
                r_stall_count <= r_stall_count + 1'b1;
        end
    end
    assign o_pc_rst      = r_pc_rst;
    assign o_pc_ena      = r_pc_ena;
    assign o_pc_jmp      = r_pc_jmp;
    assign o_pc_jmp_in   = r_pc_jmp_in;
    assign o_flush_if    = r_flush;
    assign o_flush_id    = r_flush;
    assign o_halted      = r_halted;
    assign o_stall_count = r_stall_count;
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: scoreboard bench with a behavioural model and a connected PC
module tb_fetch_sequencer;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0, stall = 1'b0, br = 1'b0, halt = 1'b0;
    logic [4:0] tgt = '0;
    logic       pc_rst, pc_ena, pc_jmp, fif, fid, halted;
    logic [4:0] jin;
    logic [7:0] cnt;
    logic       s_pc_rst, s_pc_ena, s_pc_jmp, s_fif, s_fid, s_halted;
    logic [4:0] s_jin;
    logic [1:0] s_cnt;
    logic [4:0] pc;

    fetch_sequencer #(.bus_counter(5), .cnt_width(8)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_stall_req(stall),
        .i_branch_req(br), .i_branch_target(tgt), .i_halt_req(halt),
        .o_pc_rst(pc_rst), .o_pc_ena(pc_ena), .o_pc_jmp(pc_jmp), .o_pc_jmp_in(jin),
        .o_flush_if(fif), .o_flush_id(fid), .o_halted(halted), .o_stall_count(cnt));

    fetch_sequencer #(.bus_counter(5), .cnt_width(2)) dut_s (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_stall_req(stall),
        .i_branch_req(br), .i_branch_target(tgt), .i_halt_req(halt),
        .o_pc_rst(s_pc_rst), .o_pc_ena(s_pc_ena), .o_pc_jmp(s_pc_jmp), .o_pc_jmp_in(s_jin),
        .o_flush_if(s_fif), .o_flush_id(s_fid), .o_halted(s_halted), .o_stall_count(s_cnt));

    always #5 clk = ~clk;

    // PC driven by the controller, consuming its outputs on negedge
    always @(negedge clk)
        pc <= pc_rst ? 5'h1f : pc_jmp ? jin : pc_ena ? pc + 5'd1 : pc;

    typedef struct {
        bit       prst, ena, jmp, fl, hlt;
        bit [4:0] jin;
        int       n;
    } exp_t;

    localparam int M_IDLE = 0, M_RUN = 1, M_STALL = 2, M_RED = 3, M_HALT = 4;
    exp_t     sb[$];
    bit [4:0] pc_q[$];
    exp_t     e;
    int       m_st = M_IDLE, m_n = 0;
    bit [4:0] m_tgt = '0;
    bit [4:0] exp_pc = 5'h1f;
    int       n_chk = 0, n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // One cycle of stimulus; the model applies the request rules and queues the expected outputs
    task automatic cyc(input bit s, input bit st, input bit b, input bit [4:0] t, input bit h);
        exp_t x;
        @(negedge clk);
        rst = 1'b0; start = s; stall = st; br = b; tgt = t; halt = h;
        case (m_st)
            M_IDLE:  if (s) m_st = M_RUN;
            M_RUN, M_STALL: begin
                if (b) begin m_st = M_RED; m_tgt = t; end
                else if (h) m_st = M_HALT;
                else if (st) m_st = M_STALL;
                else m_st = M_RUN;
            end
            M_RED:   m_st = M_RUN;
            default: ;
        endcase
        if (m_st == M_STALL) m_n++;
        x.prst = m_st == M_IDLE;
        x.ena  = m_st == M_RUN || m_st == M_RED;
        x.jmp  = m_st == M_RED;
        x.fl   = m_st == M_RED;
        x.hlt  = m_st == M_HALT;
        x.jin  = m_tgt;
        x.n    = m_n;
        sb.push_back(x);
    endtask

    // Reset asserted between clock edges; outputs must change without a clock edge
    task automatic arst();
        @(posedge clk);
        #3;
        rst = 1'b1;
        m_st = M_IDLE; m_tgt = '0; m_n = 0;
        exp_pc = 5'h1f;
        pc_q.delete();
        pc_q.push_back(5'h1f);
        #1;
        chk("arst_pc_rst", pc_rst, 1);
        chk("arst_pc_ena", pc_ena, 0);
        chk("arst_pc_jmp", pc_jmp, 0);
        chk("arst_flush", {fif, fid}, 0);
        chk("arst_halted", halted, 0);
        chk("arst_jmp_in", jin, 0);
        chk("arst_cnt", cnt, 0);
        chk("arst_cnt2", s_cnt, 0);
    endtask

    // Output monitor: compares each registered update against the scoreboard
    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("pc_rst", pc_rst, e.prst);
            chk("pc_ena", pc_ena, e.ena);
            chk("pc_jmp", pc_jmp, e.jmp);
            chk("flush_if", fif, e.fl);
            chk("flush_id", fid, e.fl);
            chk("halted", halted, e.hlt);
            chk("pc_jmp_in", jin, e.jin);
            chk("stall_count", cnt, e.n > 255 ? 255 : e.n);
            chk("stall_count_w2", s_cnt, e.n > 3 ? 3 : e.n);
            chk("w2_pc_ena", s_pc_ena, e.ena);
            exp_pc = e.prst ? 5'h1f : e.jmp ? e.jin : e.ena ? exp_pc + 5'd1 : exp_pc;
            pc_q.push_back(exp_pc);
        end
    end

    // PC monitor: the PC value after it consumed the controller outputs
    always @(negedge clk) begin
        #1;
        if (pc_q.size() > 0) chk("pc", pc, pc_q.pop_front());
    end

    initial begin
        cyc(0, 1, 1, 9, 1);
        cyc(1, 1, 1, 9, 1);
        repeat (10) cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 1, 5, 0);
        cyc(0, 1, 0, 0, 0);
        repeat (2) cyc(0, 0, 0, 0, 0);
        repeat (3) cyc(0, 1, 0, 0, 0);
        repeat (2) cyc(0, 0, 0, 0, 0);
        cyc(0, 1, 1, 1, 0);
        repeat (2) cyc(0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);
        cyc(0, 1, 1, 1, 0);
        repeat (2) cyc(0, 0, 0, 0, 0);
        repeat (5) cyc(0, 1, 0, 0, 0);
        cyc(0, 0, 1, 7, 0);
        arst();
        cyc(1, 0, 0, 0, 0);
        repeat (3) cyc(0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 1);
        repeat (2) cyc(1, 0, 0, 0, 0);
        cyc(0, 1, 1, 3, 0);
        cyc(1, 0, 0, 0, 0);
        arst();
        cyc(0, 0, 0, 0, 0);
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 39) == 0) arst();
            cyc($urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
                $urandom_range(0, 4) == 0, 5'($urandom), $urandom_range(0, 30) == 0);
        end
        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
